// File: rtl/train_seq_pkg.sv
// Shared state encoding and helpers for the training-pass sequencer.
package train_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD0 = 3'd1,
        S_BWD  = 3'd2,
        S_FWD  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    function automatic logic is_busy(input state_e s);
        return (s == S_FWD0) || (s == S_BWD) || (s == S_FWD);
    endfunction

endpackage

// File: rtl/train_seq_ctrl_pass_watchdog.sv
// Pass watchdog: counts enabled cycles, flags the cycle whose increment reaches all-ones.
module pass_watchdog #(
    parameter int unsigned TIMEOUT_W = 12
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clr,
    input  logic i_cnt_en,
    output logic o_expired
);

    localparam logic [TIMEOUT_W-1:0] PRE_MAX = ~(TIMEOUT_W'(1));

    logic [TIMEOUT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en) begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
        end
    end

    // Flagged combinationally so the sequencer enters ERR on the same edge the count would hit all-ones.
    assign o_expired = i_cnt_en & ~i_clr & (r_cnt == PRE_MAX);

endmodule

// File: rtl/train_seq_ctrl.sv
// N-layer training-pass sequencer: F0 pass, then alternating backward / update-forward passes.
module train_seq_ctrl
    import train_seq_pkg::*;
#(
    parameter int unsigned N_LAYERS  = 2,
    parameter int unsigned LAYER_W   = 2,
    parameter int unsigned EPOCH_W   = 8,
    parameter int unsigned TIMEOUT_W = 12
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               init_i,
    input  logic               abort_i,
    input  logic [EPOCH_W-1:0] max_epoch_i,
    input  logic               f_end_i,
    input  logic               b_end_i,
    input  logic               converged_i,
    output logic               f0_pass_o,
    output logic               f_pass_o,
    output logic               b_pass_o,
    output logic [LAYER_W-1:0] layer_o,
    output logic [EPOCH_W-1:0] epoch_o,
    output logic               zero_loss_o,
    output logic               zero_final_o,
    output logic               zero_weight_update_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o
);

    localparam logic [LAYER_W-1:0] LAST = LAYER_W'(N_LAYERS - 1);

    state_e             r_state;
    logic [LAYER_W-1:0] r_layer;
    logic [EPOCH_W-1:0] r_epoch;
    logic [EPOCH_W-1:0] r_max;
    logic               r_f0_pass, r_f_pass, r_b_pass;
    logic               r_busy, r_done, r_timeout;
    logic               r_zero_loss, r_zero_final, r_zero_wu;

    state_e             w_state_nxt;
    logic [LAYER_W-1:0] w_layer_nxt;
    logic [EPOCH_W-1:0] w_epoch_nxt;
    logic [EPOCH_W-1:0] w_max_nxt;
    logic [EPOCH_W-1:0] w_epoch_inc;
    logic               w_zero_loss, w_zero_final, w_zero_wu;
    logic               w_busy, w_end_hon, w_wd_clr, w_wd_en, w_expired;

    assign w_busy      = is_busy(r_state);
    assign w_epoch_inc = r_epoch + EPOCH_W'(1);
    assign w_end_hon   = ((r_state == S_FWD0 || r_state == S_FWD) && f_end_i)
                       || ((r_state == S_BWD) && b_end_i);

    // Inside busy states a state change only comes from an honoured end, abort or expiry,
    // so clearing on those (and whenever idle) covers every state change without a loop.
    assign w_wd_clr = en_i & (abort_i | ~w_busy | w_end_hon);
    assign w_wd_en  = en_i & w_busy;

    pass_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .i_clr     (w_wd_clr),
        .i_cnt_en  (w_wd_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_layer_nxt  = r_layer;
        w_epoch_nxt  = r_epoch;
        w_max_nxt    = r_max;
        w_zero_loss  = 1'b0;
        w_zero_final = 1'b0;
        w_zero_wu    = 1'b0;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
            w_layer_nxt = '0;
            w_epoch_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (init_i) begin
                        w_state_nxt = S_FWD0;
                        w_layer_nxt = '0;
                        w_epoch_nxt = '0;
                        w_max_nxt   = max_epoch_i;
                    end
                end
                S_FWD0: begin
                    if (w_expired) begin
                        w_state_nxt = S_ERR;
                    end else if (f_end_i) begin
                        if (r_layer < LAST) begin
                            w_layer_nxt = r_layer + LAYER_W'(1);
                        end else begin
                            w_state_nxt = S_BWD;
                            w_layer_nxt = LAST;
                        end
                    end
                end
                S_BWD: begin
                    if (w_expired) begin
                        w_state_nxt = S_ERR;
                    end else if (b_end_i) begin
                        if (r_layer > '0) begin
                            w_layer_nxt = r_layer - LAYER_W'(1);
                        end else begin
                            w_state_nxt  = S_FWD;
                            w_layer_nxt  = '0;
                            w_zero_loss  = 1'b1;
                            w_zero_final = 1'b1;
                        end
                    end
                end
                S_FWD: begin
                    if (w_expired) begin
                        w_state_nxt = S_ERR;
                    end else if (f_end_i) begin
                        if (r_layer < LAST) begin
                            w_layer_nxt = r_layer + LAYER_W'(1);
                        end else begin
                            w_zero_wu   = 1'b1;
                            w_epoch_nxt = w_epoch_inc;
                            if (converged_i || ((r_max != '0) && (w_epoch_inc == r_max))) begin
                                w_state_nxt = S_DONE;
                            end else begin
                                w_state_nxt = S_BWD;
                                w_layer_nxt = LAST;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_layer_nxt = '0;
                    w_epoch_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= S_IDLE;
            r_layer      <= '0;
            r_epoch      <= '0;
            r_max        <= '0;
            r_f0_pass    <= 1'b0;
            r_f_pass     <= 1'b0;
            r_b_pass     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_zero_loss  <= 1'b0;
            r_zero_final <= 1'b0;
            r_zero_wu    <= 1'b0;
        end else if (en_i) begin
            r_state      <= w_state_nxt;
            r_layer      <= w_layer_nxt;
            r_epoch      <= w_epoch_nxt;
            r_max        <= w_max_nxt;
            r_f0_pass    <= (w_state_nxt == S_FWD0);
            r_f_pass     <= (w_state_nxt == S_FWD);
            r_b_pass     <= (w_state_nxt == S_BWD);
            r_busy       <= is_busy(w_state_nxt);
            r_done       <= (w_state_nxt == S_DONE);
            r_timeout    <= (w_state_nxt == S_ERR);
            r_zero_loss  <= w_zero_loss;
            r_zero_final <= w_zero_final;
            r_zero_wu    <= w_zero_wu;
        end else begin
            r_zero_loss  <= 1'b0;
            r_zero_final <= 1'b0;
            r_zero_wu    <= 1'b0;
        end
    end

    assign f0_pass_o            = r_f0_pass;
    assign f_pass_o             = r_f_pass;
    assign b_pass_o             = r_b_pass;
    assign layer_o              = r_layer;
    assign epoch_o              = r_epoch;
    assign zero_loss_o          = r_zero_loss;
    assign zero_final_o         = r_zero_final;
    assign zero_weight_update_o = r_zero_wu;
    assign busy_o               = r_busy;
    assign done_o               = r_done;
    assign timeout_o            = r_timeout;

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Directed bench for train_seq_ctrl (2 layers, 4-bit watchdog): vector table plus multi-cycle sequences.
module tb_train_seq_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       en_i = 1'b0, init_i = 1'b0, abort_i = 1'b0;
    logic [7:0] max_epoch_i = '0;
    logic       f_end_i = 1'b0, b_end_i = 1'b0, converged_i = 1'b0;
    logic       f0_pass_o, f_pass_o, b_pass_o;
    logic [1:0] layer_o;
    logic [7:0] epoch_o;
    logic       zero_loss_o, zero_final_o, zero_weight_update_o;
    logic       busy_o, done_o, timeout_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_zw    = 0;

    always #5 clk_i = ~clk_i;

    train_seq_ctrl #(
        .N_LAYERS  (2),
        .LAYER_W   (2),
        .EPOCH_W   (8),
        .TIMEOUT_W (4)
    ) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .en_i                 (en_i),
        .init_i               (init_i),
        .abort_i              (abort_i),
        .max_epoch_i          (max_epoch_i),
        .f_end_i              (f_end_i),
        .b_end_i              (b_end_i),
        .converged_i          (converged_i),
        .f0_pass_o            (f0_pass_o),
        .f_pass_o             (f_pass_o),
        .b_pass_o             (b_pass_o),
        .layer_o              (layer_o),
        .epoch_o              (epoch_o),
        .zero_loss_o          (zero_loss_o),
        .zero_final_o         (zero_final_o),
        .zero_weight_update_o (zero_weight_update_o),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .timeout_o            (timeout_o)
    );

    typedef struct {
        int          en, ini, ab, fe, be, cv, mx;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    // Packed view: {f0, f, b, layer[1:0], epoch[7:0], zl, zf, zw, busy, done, timeout}
    function automatic logic [31:0] mkv(input int f0, f, b, l, e, zl, zf, zw, bs, dn, to);
        return {13'd0, 1'(f0), 1'(f), 1'(b), 2'(l), 8'(e), 1'(zl), 1'(zf), 1'(zw), 1'(bs), 1'(dn), 1'(to)};
    endfunction

    function automatic logic [31:0] act();
        return {13'd0, f0_pass_o, f_pass_o, b_pass_o, layer_o, epoch_o,
                zero_loss_o, zero_final_o, zero_weight_update_o, busy_o, done_o, timeout_o};
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
        end
    endtask

    task automatic step(input int en, ini, ab, fe, be, cv, mx);
        en_i        = 1'(en);
        init_i      = 1'(ini);
        abort_i     = 1'(ab);
        f_end_i     = 1'(fe);
        b_end_i     = 1'(be);
        converged_i = 1'(cv);
        max_epoch_i = 8'(mx);
        @(posedge clk_i);
        #1;
        if (zero_weight_update_o) n_zw++;
    endtask

    int pl_pass[14], pl_layer[14], pl_epoch[14];

    initial begin
        // en ini ab fe be cv mx : expected after the edge
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[1]  = '{1, 0, 0, 1, 0, 0, 0, mkv(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        tbl[2]  = '{1, 0, 0, 0, 1, 0, 0, mkv(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        tbl[3]  = '{1, 0, 0, 1, 1, 0, 0, mkv(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
        tbl[4]  = '{1, 0, 0, 1, 0, 0, 0, mkv(0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0)};
        tbl[5]  = '{1, 0, 0, 0, 1, 0, 0, mkv(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[6]  = '{1, 0, 0, 0, 1, 0, 0, mkv(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0)};
        tbl[7]  = '{1, 0, 0, 0, 0, 0, 0, mkv(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[8]  = '{1, 0, 0, 1, 0, 1, 0, mkv(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0)};
        tbl[9]  = '{1, 0, 0, 1, 0, 1, 0, mkv(0, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0)};
        tbl[10] = '{1, 0, 0, 1, 1, 0, 0, mkv(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0)};
        tbl[11] = '{1, 1, 0, 0, 0, 0, 0, mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
        tbl[12] = '{1, 0, 1, 1, 0, 0, 0, mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[13] = '{1, 0, 0, 1, 0, 0, 0, mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

        // Expected pass order for a 3-epoch run: 0=F0, 1=B, 2=F
        pl_pass[0] = 0; pl_layer[0] = 0; pl_epoch[0] = 0;
        pl_pass[1] = 0; pl_layer[1] = 1; pl_epoch[1] = 0;
        for (int k = 0; k < 3; k++) begin
            pl_pass[2+4*k] = 1; pl_layer[2+4*k] = 1; pl_epoch[2+4*k] = k;
            pl_pass[3+4*k] = 1; pl_layer[3+4*k] = 0; pl_epoch[3+4*k] = k;
            pl_pass[4+4*k] = 2; pl_layer[4+4*k] = 0; pl_epoch[4+4*k] = k;
            pl_pass[5+4*k] = 2; pl_layer[5+4*k] = 1; pl_epoch[5+4*k] = k;
        end

        repeat (2) @(posedge clk_i);
        #1;
        check("reset", act(), '0);
        rst_i = 1'b1;

        // Full run to the epoch limit, strobes 3 cycles apart
        step(1, 1, 0, 0, 0, 0, 3);
        n_zw = 0;
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0, 0, 0, 0, 3);
            step(1, 0, 0, 0, 0, 0, 3);
            check($sformatf("t1_pass%0d", i), act(),
                  mkv(pl_pass[i] == 0, pl_pass[i] == 2, pl_pass[i] == 1, pl_layer[i], pl_epoch[i],
                      0, 0, 0, 1, 0, 0));
            step(1, 0, 0, pl_pass[i] != 1, pl_pass[i] == 1, 0, 3);
        end
        check("t1_done", act(), mkv(0, 0, 0, 1, 3, 0, 0, 1, 0, 1, 0));
        check("t1_zw_count", 32'(n_zw), 32'd3);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, tbl[i].ini, tbl[i].ab, tbl[i].fe, tbl[i].be, tbl[i].cv, tbl[i].mx);
            check($sformatf("vec%0d", i), act(), tbl[i].exp);
        end

        // Enable freeze right after a strobe cycle
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("t4_strobe", act(), mkv(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, i % 2 == 0, 0, 0, 0);
            check($sformatf("t4_frozen%0d", i), act(), mkv(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        end
        step(1, 0, 0, 1, 0, 0, 0);
        check("t4_resume", act(), mkv(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        step(1, 1, 0, 0, 0, 0, 0);
        check("t4_init_busy", act(), mkv(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        step(1, 0, 1, 0, 0, 0, 0);
        check("t4_abort", act(), '0);

        // Watchdog expiry in FWD0 at layer 1
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0, 0, 0);
        check("t5_pre_expiry", act(), mkv(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        step(1, 0, 0, 0, 0, 0, 0);
        check("t5_err", act(), mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        step(1, 0, 0, 1, 0, 0, 0);
        check("t5_err_hold", act(), mkv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        step(1, 1, 0, 0, 0, 0, 0);
        check("t5_recover", act(), mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        // Asynchronous reset mid-FWD
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("t6_in_fwd", act(), mkv(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        #2 rst_i = 1'b0;
        #1 check("t6_async_rst", act(), '0);
        #1 rst_i = 1'b1;
        step(1, 0, 0, 1, 0, 0, 0);
        check("t6_idle_fend", act(), '0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("t6_idle_bend", act(), '0);
        step(1, 1, 0, 0, 0, 0, 0);
        check("t6_restart", act(), mkv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
